sccb_config_sequencer: RTL and testbench



---
 rtl/sccb_cfg_pkg.sv | 30 +++
 rtl/sccb_cfg_timer.sv | 27 ++
 rtl/sccb_config_sequencer.sv | 154 +++++++++++++++
 tb/tb_sccb_config_sequencer.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sccb_cfg_pkg.sv
// Shared types, constants and the default OV7670 register table for the
// SCCB configuration sequencer.
package sccb_cfg_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        ISSUE,
        RETRY,
        RELEASE,
        DELAY,
        DONE,
        ERROR
    } sccb_cfg_state_t;

    localparam logic [7:0]  SCCB_DELAY_ADDR = 8'hFF;
    localparam logic [15:0] SCCB_END        = 16'hFFFF;

    // COM7 soft reset, 10 ms settle, COM7 RGB, COM15 RGB565, END
    function automatic logic [15:0] OV7670_CFG(input logic [7:0] index);
        case (index)
            8'd0:    return 16'h1280;
            8'd1:    return 16'hFF0A;
            8'd2:    return 16'h1204;
            8'd3:    return 16'h40D0;
            default: return SCCB_END;
        endcase
    endfunction

endpackage

// File: rtl/sccb_cfg_timer.sv
// Shared counter: counts down for delay entries, counts up for the write timeout.
module sccb_cfg_timer #(
    parameter int WIDTH = 32
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             count_up,
    input  logic             count_down,
    output logic [WIDTH-1:0] count
);

    // Down-counting saturates at zero so a zero-length delay cannot wrap
    always_ff @(posedge Clk) begin
        if (Reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (count_up) begin
            count <= count + 1'b1;
        end else if (count_down && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

endmodule

// File: rtl/sccb_config_sequencer.sv
// Walks the OV7670 register table at power-up and feeds one 3-phase write
// per entry into SCCB_master, with inline delays, timeout and bounded retry.
module sccb_config_sequencer
    import sccb_cfg_pkg::*;
#(
    parameter int TABLE_LEN  = 5,
    parameter int DELAY_UNIT = 50000,
    parameter int TIMEOUT    = 65536,
    parameter int MAX_RETRY  = 3
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       start,
    input  logic       sccb_complete,
    output logic       sccb_write_rq,
    output logic [7:0] sccb_addr,
    output logic [7:0] sccb_data,
    output logic       busy,
    output logic       done,
    output logic       error,
    output logic [7:0] reg_index
);

    localparam int               TIMER_W      = 32;
    localparam logic [8:0]       TABLE_END    = 9'(TABLE_LEN);
    localparam logic [TIMER_W-1:0] TIMEOUT_LAST = 32'(TIMEOUT - 1);
    localparam logic [7:0]       RETRY_LIMIT  = 8'(MAX_RETRY);

    sccb_cfg_state_t     state;
    logic [8:0]          entry_pos;
    logic [7:0]          retry_count;
    logic [15:0]         entry;
    logic                entry_is_end;
    logic                entry_is_delay;
    logic                timer_load;
    logic                timer_up;
    logic                timer_down;
    logic [TIMER_W-1:0]  timer_load_value;
    logic [TIMER_W-1:0]  timer_count;

    // A ninth position bit lets TABLE_LEN=256 end cleanly when the 8-bit index wraps
    assign entry          = OV7670_CFG(entry_pos[7:0]);
    assign entry_is_end   = (entry == SCCB_END) || (entry_pos >= TABLE_END);
    assign entry_is_delay = (entry[15:8] == SCCB_DELAY_ADDR);
    assign reg_index      = entry_pos[7:0];

    always_comb begin
        timer_load       = 1'b0;
        timer_load_value = '0;
        timer_up         = 1'b0;
        timer_down       = 1'b0;
        case (state)
            FETCH: begin
                timer_load = 1'b1;
                if (entry_is_delay) begin
                    timer_load_value = 32'(entry[7:0]) * 32'(DELAY_UNIT);
                end
            end
            ISSUE:   timer_up   = 1'b1;
            DELAY:   timer_down = 1'b1;
            default: ;
        endcase
    end

    sccb_cfg_timer #(
        .WIDTH(TIMER_W)
    ) u_timer (
        .Clk       (Clk),
        .Reset     (Reset),
        .load      (timer_load),
        .load_value(timer_load_value),
        .count_up  (timer_up),
        .count_down(timer_down),
        .count     (timer_count)
    );

    // Outputs are registered alongside the next state so they track it exactly
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state         <= IDLE;
            entry_pos     <= '0;
            retry_count   <= '0;
            sccb_write_rq <= 1'b0;
            sccb_addr     <= '0;
            sccb_data     <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            error         <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start && !sccb_complete) begin
                        state       <= FETCH;
                        entry_pos   <= '0;
                        retry_count <= '0;
                        done        <= 1'b0;
                        error       <= 1'b0;
                        busy        <= 1'b1;
                    end
                end
                FETCH: begin
                    if (entry_is_end) begin
                        state <= DONE;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                    end else if (entry_is_delay) begin
                        state <= DELAY;
                    end else begin
                        state         <= ISSUE;
                        sccb_addr     <= entry[15:8];
                        sccb_data     <= entry[7:0];
                        sccb_write_rq <= 1'b1;
                    end
                end
                ISSUE: begin
                    if (sccb_complete) begin
                        state         <= RELEASE;
                        sccb_write_rq <= 1'b0;
                        retry_count   <= '0;
                        entry_pos     <= entry_pos + 9'd1;
                    end else if (timer_count == TIMEOUT_LAST) begin
                        state         <= RETRY;
                        sccb_write_rq <= 1'b0;
                    end
                end
                RETRY: begin
                    if (retry_count < RETRY_LIMIT) begin
                        retry_count <= retry_count + 8'd1;
                        state       <= RELEASE;
                    end else begin
                        state <= ERROR;
                        error <= 1'b1;
                        busy  <= 1'b0;
                    end
                end
                RELEASE: begin
                    if (!sccb_complete) begin
                        state <= FETCH;
                    end
                end
                DELAY: begin
                    if (timer_count <= 32'd1) begin
                        entry_pos <= entry_pos + 9'd1;
                        state     <= FETCH;
                    end
                end
                DONE:    state <= IDLE;
                ERROR:   state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sccb_config_sequencer.sv
// Directed bench for sccb_config_sequencer with a small SCCB_master responder.
module tb_sccb_config_sequencer;

    localparam int ACK_DELAY     = 5;
    localparam int RELEASE_DELAY = 2;

    logic       Clk;
    logic       Reset;
    logic       start;
    logic       start_short;
    logic       sccb_complete;
    logic       sel_short;

    logic       rq, busy, done, error;
    logic [7:0] addr, data, idx;
    logic       rq_s, busy_s, done_s, error_s;
    logic [7:0] addr_s, data_s, idx_s;

    logic       m_rq, m_busy, m_done, m_error;
    logic [7:0] m_addr, m_data, m_idx;

    int checks;
    int errors;

    int          wr_count;
    logic [15:0] wr_entry [16];
    int          wr_rise  [16];
    int          wr_len   [16];
    int          end_sample;
    int          stable_violations;

    sccb_config_sequencer #(
        .TABLE_LEN(5), .DELAY_UNIT(4), .TIMEOUT(20), .MAX_RETRY(2)
    ) dut (
        .Clk(Clk), .Reset(Reset), .start(start), .sccb_complete(sccb_complete),
        .sccb_write_rq(rq), .sccb_addr(addr), .sccb_data(data),
        .busy(busy), .done(done), .error(error), .reg_index(idx)
    );

    sccb_config_sequencer #(
        .TABLE_LEN(2), .DELAY_UNIT(4), .TIMEOUT(20), .MAX_RETRY(2)
    ) dut_short (
        .Clk(Clk), .Reset(Reset), .start(start_short), .sccb_complete(sccb_complete),
        .sccb_write_rq(rq_s), .sccb_addr(addr_s), .sccb_data(data_s),
        .busy(busy_s), .done(done_s), .error(error_s), .reg_index(idx_s)
    );

    assign m_rq    = sel_short ? rq_s    : rq;
    assign m_addr  = sel_short ? addr_s  : addr;
    assign m_data  = sel_short ? data_s  : data;
    assign m_busy  = sel_short ? busy_s  : busy;
    assign m_done  = sel_short ? done_s  : done;
    assign m_error = sel_short ? error_s : error;
    assign m_idx   = sel_short ? idx_s   : idx;

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic pulse_start(input bit short_dut);
        @(negedge Clk);
        if (short_dut) start_short = 1'b1;
        else           start       = 1'b1;
        @(negedge Clk);
        start       = 1'b0;
        start_short = 1'b0;
    endtask

    // Responder: acks ACK_DELAY samples into a request, releases RELEASE_DELAY after the drop
    task automatic run_model(input int max_cycles, input logic [15:0] never_ack,
                             input bit drop_first, input int start_at);
        int          hi_cnt;
        int          lo_cnt;
        bit          prev_rq;
        logic [15:0] cur;
        wr_count = 0; end_sample = -1; stable_violations = 0;
        hi_cnt = 0; lo_cnt = 0; prev_rq = 1'b0; cur = '0;
        for (int s = 1; s <= max_cycles; s++) begin
            @(negedge Clk);
            start = (s == start_at);
            if (m_rq) begin
                if (!prev_rq) begin
                    cur = {m_addr, m_data};
                    if (wr_count < 16) begin
                        wr_entry[wr_count] = cur;
                        wr_rise[wr_count]  = s;
                        wr_len[wr_count]   = 0;
                    end
                    wr_count++;
                end else if ({m_addr, m_data} !== cur) begin
                    stable_violations++;
                end
                if (wr_count <= 16) wr_len[wr_count-1]++;
                hi_cnt++;
                if (hi_cnt == ACK_DELAY && cur != never_ack && !(drop_first && wr_count == 1))
                    sccb_complete = 1'b1;
            end else begin
                hi_cnt = 0;
                if (sccb_complete) begin
                    lo_cnt++;
                    if (lo_cnt == RELEASE_DELAY) begin
                        sccb_complete = 1'b0;
                        lo_cnt = 0;
                    end
                end
            end
            prev_rq = m_rq;
            if (m_done || m_error) begin
                end_sample = s;
                break;
            end
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        repeat (3) @(negedge Clk);
        checks++;
        if ({rq, addr, data, busy, done, error, idx} !== 28'h0) begin
            errors++;
            $display("[TB] FAIL reset_outputs: got %h expected 0", {rq, addr, data, busy, done, error, idx});
        end
        checks++;
        if ({rq_s, addr_s, data_s, busy_s, done_s, error_s, idx_s} !== 28'h0) begin
            errors++;
            $display("[TB] FAIL reset_outputs_short: got %h expected 0", {rq_s, addr_s, data_s, busy_s, done_s, error_s, idx_s});
        end
        Reset = 1'b0;
        @(negedge Clk);
    endtask

    task automatic test_default_table();
        logic [15:0] exp_w [3] = '{16'h1280, 16'h1204, 16'h40D0};
        int          exp_r [3] = '{1, 50, 58};
        pulse_start(1'b0);
        checks++;
        if (busy !== 1'b1 || rq !== 1'b0) begin
            errors++;
            $display("[TB] FAIL fetch_cycle: busy=%b rq=%b expected busy=1 rq=0", busy, rq);
        end
        run_model(300, 16'h0000, 1'b0, 0);
        checks++;
        if (wr_count !== 3) begin
            errors++;
            $display("[TB] FAIL default_write_count: got %0d expected 3", wr_count);
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (wr_entry[i] !== exp_w[i] || wr_rise[i] !== exp_r[i]) begin
                errors++;
                $display("[TB] FAIL default_write%0d: got %h@%0d expected %h@%0d", i, wr_entry[i], wr_rise[i], exp_w[i], exp_r[i]);
            end
        end
        checks++;
        if (end_sample !== 66 || done !== 1'b1 || busy !== 1'b0 || error !== 1'b0) begin
            errors++;
            $display("[TB] FAIL default_finish: end=%0d done=%b busy=%b error=%b expected 66 1 0 0", end_sample, done, busy, error);
        end
        checks++;
        if (idx !== 8'd4 || rq !== 1'b0) begin
            errors++;
            $display("[TB] FAIL default_index: got idx=%0d rq=%b expected 4 0", idx, rq);
        end
        checks++;
        if (stable_violations !== 0) begin
            errors++;
            $display("[TB] FAIL addr_data_stable: got %0d changes expected 0", stable_violations);
        end
        @(negedge Clk);
    endtask

    task automatic test_timeout_error();
        int exp_r [4] = '{1, 50, 73, 96};
        pulse_start(1'b0);
        run_model(300, 16'h1204, 1'b0, 0);
        checks++;
        if (wr_count !== 4) begin
            errors++;
            $display("[TB] FAIL timeout_request_count: got %0d expected 4", wr_count);
        end
        for (int i = 1; i < 4; i++) begin
            checks++;
            if (wr_entry[i] !== 16'h1204 || wr_rise[i] !== exp_r[i] || wr_len[i] !== 20) begin
                errors++;
                $display("[TB] FAIL timeout_request%0d: got %h@%0d len %0d expected 1204@%0d len 20", i, wr_entry[i], wr_rise[i], wr_len[i], exp_r[i]);
            end
        end
        checks++;
        if (end_sample !== 117 || error !== 1'b1 || done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL timeout_error: end=%0d error=%b done=%b busy=%b expected 117 1 0 0", end_sample, error, done, busy);
        end
        checks++;
        if (idx !== 8'd2 || rq !== 1'b0) begin
            errors++;
            $display("[TB] FAIL timeout_index: got idx=%0d rq=%b expected 2 0", idx, rq);
        end
        @(negedge Clk);
    endtask

    task automatic test_retry_recovers();
        logic [15:0] exp_w [4] = '{16'h1280, 16'h1280, 16'h1204, 16'h40D0};
        int          exp_r [4] = '{1, 24, 73, 81};
        pulse_start(1'b0);
        run_model(300, 16'h0000, 1'b1, 0);
        checks++;
        if (wr_count !== 4 || wr_len[0] !== 20) begin
            errors++;
            $display("[TB] FAIL retry_count: got %0d writes first len %0d expected 4 and 20", wr_count, wr_len[0]);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (wr_entry[i] !== exp_w[i] || wr_rise[i] !== exp_r[i]) begin
                errors++;
                $display("[TB] FAIL retry_write%0d: got %h@%0d expected %h@%0d", i, wr_entry[i], wr_rise[i], exp_w[i], exp_r[i]);
            end
        end
        checks++;
        if (end_sample !== 89 || done !== 1'b1 || error !== 1'b0) begin
            errors++;
            $display("[TB] FAIL retry_finish: end=%0d done=%b error=%b expected 89 1 0", end_sample, done, error);
        end
        @(negedge Clk);
    endtask

    task automatic test_reset_mid_write();
        pulse_start(1'b0);
        run_model(3, 16'h0000, 1'b0, 0);
        checks++;
        if (rq !== 1'b1) begin
            errors++;
            $display("[TB] FAIL mid_write_rq: got %b expected 1", rq);
        end
        @(negedge Clk);
        Reset = 1'b1;
        @(negedge Clk);
        checks++;
        if ({rq, addr, data, busy, done, error, idx} !== 28'h0) begin
            errors++;
            $display("[TB] FAIL mid_reset_outputs: got %h expected 0", {rq, addr, data, busy, done, error, idx});
        end
        Reset = 1'b0;
        pulse_start(1'b0);
        run_model(300, 16'h0000, 1'b0, 0);
        checks++;
        if (wr_entry[0] !== 16'h1280 || wr_rise[0] !== 1 || end_sample !== 66 || done !== 1'b1) begin
            errors++;
            $display("[TB] FAIL restart_after_reset: got %h@%0d end=%0d done=%b expected 1280@1 66 1", wr_entry[0], wr_rise[0], end_sample, done);
        end
        @(negedge Clk);
    endtask

    task automatic test_start_ignored();
        pulse_start(1'b0);
        run_model(300, 16'h0000, 1'b0, 52);
        checks++;
        if (wr_count !== 3 || wr_rise[2] !== 58 || end_sample !== 66 || idx !== 8'd4) begin
            errors++;
            $display("[TB] FAIL start_while_busy: writes=%0d rise2=%0d end=%0d idx=%0d expected 3 58 66 4", wr_count, wr_rise[2], end_sample, idx);
        end
        @(negedge Clk);
        sccb_complete = 1'b1;
        start = 1'b1;
        @(negedge Clk);
        start = 1'b0;
        @(negedge Clk);
        checks++;
        if (busy !== 1'b0 || rq !== 1'b0 || done !== 1'b1) begin
            errors++;
            $display("[TB] FAIL start_with_complete: busy=%b rq=%b done=%b expected 0 0 1", busy, rq, done);
        end
        sccb_complete = 1'b0;
        @(negedge Clk);
    endtask

    task automatic test_short_table();
        sel_short = 1'b1;
        pulse_start(1'b1);
        run_model(300, 16'h0000, 1'b0, 0);
        checks++;
        if (wr_count !== 1 || wr_entry[0] !== 16'h1280) begin
            errors++;
            $display("[TB] FAIL short_writes: got %0d first %h expected 1 and 1280", wr_count, wr_entry[0]);
        end
        checks++;
        if (end_sample !== 50 || m_done !== 1'b1 || m_busy !== 1'b0 || m_error !== 1'b0 || m_idx !== 8'd2) begin
            errors++;
            $display("[TB] FAIL short_finish: end=%0d done=%b busy=%b error=%b idx=%0d expected 50 1 0 0 2", end_sample, m_done, m_busy, m_error, m_idx);
        end
        sel_short = 1'b0;
        @(negedge Clk);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        Reset = 1'b1;
        start = 1'b0;
        start_short = 1'b0;
        sccb_complete = 1'b0;
        sel_short = 1'b0;
        test_reset();
        test_default_table();
        test_timeout_error();
        test_retry_recovers();
        test_reset_mid_write();
        test_start_ignored();
        test_short_table();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
